// File: rtl/core_pkg.sv
// Shared opcode, access-size and FSM definitions for the memory stage.
// Also holds the byte-enable and store-lane helpers.
package core_pkg;

    localparam logic [6:0] OPC_LOAD  = 7'b0000011;
    localparam logic [6:0] OPC_STORE = 7'b0100011;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    typedef enum logic [1:0] {
        IDLE        = 2'd0,
        WAIT_GNT    = 2'd1,
        WAIT_RVALID = 2'd2
    } state_e;

    // Unsupported size codes fault the same way as a misaligned access.
    function automatic logic is_misaligned(input logic [2:0] f3,
                                           input logic [1:0] lane);
        logic mis;
        case (f3)
            F3_B, F3_BU: mis = 1'b0;
            F3_H, F3_HU: mis = lane[0];
            F3_W:        mis = (lane != 2'b00);
            default:     mis = 1'b1;
        endcase
        return mis;
    endfunction

    function automatic logic [3:0] store_be(input logic [2:0] f3,
                                            input logic [1:0] lane);
        logic [3:0] be;
        case (f3[1:0])
            2'b00:   be = 4'b0001 << lane;
            2'b01:   be = 4'b0011 << lane;
            default: be = 4'b1111;
        endcase
        return be;
    endfunction

    function automatic logic [31:0] store_data(input logic [2:0]  f3,
                                               input logic [31:0] d);
        logic [31:0] w;
        case (f3[1:0])
            2'b00:   w = {4{d[7:0]}};
            2'b01:   w = {2{d[15:0]}};
            default: w = d;
        endcase
        return w;
    endfunction

endpackage

// File: rtl/load_align.sv
// Load data alignment: picks the addressed lane out of the bus word
// and sign- or zero-extends it to 32 bits.
module load_align
    import core_pkg::*;
(
    input  logic [2:0]  funct3_i,
    input  logic [1:0]  lane_i,
    input  logic [31:0] rdata_i,
    output logic [31:0] value_o
);

    logic [31:0] shifted;

    assign shifted = rdata_i >> {lane_i, 3'b000};

    always_comb begin
        value_o = shifted;
        case (funct3_i)
            F3_B:    value_o = {{24{shifted[7]}}, shifted[7:0]};
            F3_H:    value_o = {{16{shifted[15]}}, shifted[15:0]};
            F3_BU:   value_o = {24'h0, shifted[7:0]};
            F3_HU:   value_o = {16'h0, shifted[15:0]};
            default: value_o = shifted;
        endcase
    end

endmodule

// File: rtl/mem_access.sv
// Memory-access pipeline stage: forwards ALU results, runs loads/stores
// over a req/gnt/rvalid data bus and reports misaligned accesses.
module mem_access
    import core_pkg::*;
(
    input  logic        req,
    input  logic        reset,
    input  logic        valid_in,
    input  logic [6:0]  alu_opcode_in,
    input  logic [2:0]  funct3_in,
    input  logic [31:0] result_in,
    input  logic [31:0] rs2_value_in,
    input  logic [4:0]  rd_in,
    input  logic        rd_write_in,
    output logic        stall_out,
    output logic        data_req_out,
    input  logic        data_gnt_in,
    output logic [31:0] data_addr_out,
    output logic        data_we_out,
    output logic [3:0]  data_be_out,
    output logic [31:0] data_wdata_out,
    input  logic        data_rvalid_in,
    input  logic [31:0] data_rdata_in,
    output logic        valid_out,
    output logic [4:0]  rd_out,
    output logic        rd_write_out,
    output logic [31:0] rd_value_out,
    output logic        misaligned_out
);

    state_e      state_q;
    logic [31:0] addr_q;
    logic        we_q;
    logic [3:0]  be_q;
    logic [31:0] wdata_q;
    logic [2:0]  f3_q;
    logic [1:0]  lane_q;
    logic [4:0]  pend_rd_q;
    logic        pend_wr_q;
    logic        valid_q;
    logic [4:0]  rd_q;
    logic        rd_write_q;
    logic [31:0] rd_value_q;
    logic        mis_q;

    logic        is_load;
    logic        is_store;
    logic [31:0] load_d;

    assign is_load  = (alu_opcode_in == OPC_LOAD);
    assign is_store = (alu_opcode_in == OPC_STORE);

    load_align u_align (
        .funct3_i (f3_q),
        .lane_i   (lane_q),
        .rdata_i  (data_rdata_in),
        .value_o  (load_d)
    );

    always_ff @(posedge req) begin
        if (reset) begin
            state_q    <= IDLE;
            addr_q     <= '0;
            we_q       <= 1'b0;
            be_q       <= '0;
            wdata_q    <= '0;
            f3_q       <= '0;
            lane_q     <= '0;
            pend_rd_q  <= '0;
            pend_wr_q  <= 1'b0;
            valid_q    <= 1'b0;
            rd_q       <= '0;
            rd_write_q <= 1'b0;
            rd_value_q <= '0;
            mis_q      <= 1'b0;
        end else begin
            valid_q <= 1'b0;
            mis_q   <= 1'b0;
            unique case (state_q)
                IDLE: begin
                    if (valid_in) begin
                        if (!(is_load || is_store)) begin
                            valid_q    <= 1'b1;
                            rd_q       <= rd_in;
                            rd_write_q <= rd_write_in;
                            rd_value_q <= result_in;
                        end else if (is_misaligned(funct3_in, result_in[1:0])) begin
                            valid_q    <= 1'b1;
                            mis_q      <= 1'b1;
                            rd_q       <= rd_in;
                            rd_write_q <= 1'b0;
                            rd_value_q <= result_in;
                        end else begin
                            state_q   <= WAIT_GNT;
                            addr_q    <= {result_in[31:2], 2'b00};
                            we_q      <= is_store;
                            be_q      <= is_store ? store_be(funct3_in, result_in[1:0])
                                                  : 4'b1111;
                            wdata_q   <= is_store ? store_data(funct3_in, rs2_value_in)
                                                  : '0;
                            f3_q      <= funct3_in;
                            lane_q    <= result_in[1:0];
                            pend_rd_q <= rd_in;
                            pend_wr_q <= rd_write_in;
                        end
                    end
                end
                WAIT_GNT: begin
                    if (data_gnt_in) begin
                        if (we_q) begin
                            state_q    <= IDLE;
                            valid_q    <= 1'b1;
                            rd_q       <= pend_rd_q;
                            rd_write_q <= 1'b0;
                            rd_value_q <= '0;
                        end else begin
                            state_q <= WAIT_RVALID;
                        end
                    end
                end
                WAIT_RVALID: begin
                    if (data_rvalid_in) begin
                        state_q    <= IDLE;
                        valid_q    <= 1'b1;
                        rd_q       <= pend_rd_q;
                        rd_write_q <= pend_wr_q;
                        rd_value_q <= load_d;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign stall_out      = (state_q != IDLE);
    assign data_req_out   = (state_q == WAIT_GNT);
    assign data_addr_out  = addr_q;
    assign data_we_out    = we_q;
    assign data_be_out    = be_q;
    assign data_wdata_out = wdata_q;
    assign valid_out      = valid_q;
    assign rd_out         = rd_q;
    assign rd_write_out   = rd_write_q;
    assign rd_value_out   = rd_value_q;
    assign misaligned_out = mis_q;

endmodule

// File: tb/tb_mem_access.sv
// Bench for mem_access: directed vector table, hand-written corner
// sequences and random instructions against a byte-level model.
module tb_mem_access;

    localparam logic [6:0] OP_LD  = 7'b0000011;
    localparam logic [6:0] OP_ST  = 7'b0100011;
    localparam logic [6:0] OP_ALU = 7'b0010011;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        valid_in = 1'b0;
    logic [6:0]  opc = '0;
    logic [2:0]  f3 = '0;
    logic [31:0] res = '0;
    logic [31:0] rs2 = '0;
    logic [4:0]  rd = '0;
    logic        rdw = 1'b0;
    logic        gnt = 1'b0;
    logic        rvalid = 1'b0;
    logic [31:0] rdata = '0;
    logic        stall, dreq, dwe, vout, rdwo, mis;
    logic [31:0] daddr, dwdata, rdval;
    logic [3:0]  dbe;
    logic [4:0]  rdo;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    mem_access dut (
        .req            (clk),
        .reset          (rst),
        .valid_in       (valid_in),
        .alu_opcode_in  (opc),
        .funct3_in      (f3),
        .result_in      (res),
        .rs2_value_in   (rs2),
        .rd_in          (rd),
        .rd_write_in    (rdw),
        .stall_out      (stall),
        .data_req_out   (dreq),
        .data_gnt_in    (gnt),
        .data_addr_out  (daddr),
        .data_we_out    (dwe),
        .data_be_out    (dbe),
        .data_wdata_out (dwdata),
        .data_rvalid_in (rvalid),
        .data_rdata_in  (rdata),
        .valid_out      (vout),
        .rd_out         (rdo),
        .rd_write_out   (rdwo),
        .rd_value_out   (rdval),
        .misaligned_out (mis)
    );

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reference model: access size in bytes, 0 = unsupported.
    function automatic int sz(input logic [2:0] f);
        case (f)
            3'b000, 3'b100: return 1;
            3'b001, 3'b101: return 2;
            3'b010:         return 4;
            default:        return 0;
        endcase
    endfunction

    function automatic bit m_mis(input logic [2:0] f, input logic [31:0] a);
        int s = sz(f);
        return (s == 0) || ((a % s) != 0);
    endfunction

    function automatic logic [3:0] m_be(input bit st, input logic [2:0] f,
                                        input logic [31:0] a);
        logic [3:0] be = '0;
        int base = int'(a % 4);
        if (!st) return 4'hF;
        for (int i = 0; i < sz(f); i++) be[base + i] = 1'b1;
        return be;
    endfunction

    function automatic logic [31:0] m_wd(input logic [2:0] f,
                                         input logic [31:0] d);
        logic [31:0] w = '0;
        int s = sz(f);
        for (int i = 0; i < 4; i++) w[8*i +: 8] = d[8*(i % s) +: 8];
        return w;
    endfunction

    function automatic logic [31:0] m_ld(input logic [2:0] f,
                                         input logic [31:0] a,
                                         input logic [31:0] d);
        logic [31:0] v = d >> (8 * (a % 4));
        if (sz(f) == 1) begin
            v = v & 32'hFF;
            if (!f[2] && v[7]) v = v | 32'hFFFFFF00;
        end else if (sz(f) == 2) begin
            v = v & 32'hFFFF;
            if (!f[2] && v[15]) v = v | 32'hFFFF0000;
        end
        return v;
    endfunction

    task automatic run(input string nm, input logic [6:0] op,
                       input logic [2:0] f, input logic [31:0] r,
                       input logic [31:0] d2, input logic [4:0] rdi,
                       input logic rwi, input int gd, input int rdl,
                       input logic [31:0] rdat, input logic [3:0] ebe,
                       input logic [31:0] ewd, input logic [31:0] eval,
                       input logic emis);
        bit ld = (op == OP_LD);
        bit st = (op == OP_ST);
        bit mem = (ld || st) && !emis;
        valid_in = 1'b1; opc = op; f3 = f; res = r;
        rs2 = d2; rd = rdi; rdw = rwi;
        tick();
        valid_in = 1'b0; res = $urandom; rs2 = $urandom;
        rd = 5'($urandom); f3 = 3'($urandom);
        if (!mem) begin
            chk({nm, "/valid"}, vout, 1);
            chk({nm, "/req"}, dreq, 0);
            chk({nm, "/mis"}, mis, emis);
            if (emis) begin
                chk({nm, "/rdw"}, rdwo, 0);
            end else begin
                chk({nm, "/rd"}, rdo, rdi);
                chk({nm, "/rdw"}, rdwo, rwi);
                chk({nm, "/value"}, rdval, eval);
            end
            tick();
            chk({nm, "/pulse"}, vout, 0);
            return;
        end
        for (int c = 0; c <= gd; c++) begin
            chk({nm, "/req"}, dreq, 1);
            chk({nm, "/stall"}, stall, 1);
            chk({nm, "/addr"}, daddr, {r[31:2], 2'b00});
            chk({nm, "/we"}, dwe, st);
            chk({nm, "/be"}, dbe, ebe);
            if (st) chk({nm, "/wdata"}, dwdata, ewd);
            chk({nm, "/early"}, vout, 0);
            gnt = (c == gd);
            rvalid = 1'($urandom);
            rdata = $urandom;
            tick();
        end
        gnt = 1'b0; rvalid = 1'b0;
        if (st) begin
            chk({nm, "/valid"}, vout, 1);
            chk({nm, "/rdw"}, rdwo, 0);
            chk({nm, "/req_drop"}, dreq, 0);
            chk({nm, "/stall"}, stall, 0);
        end else begin
            for (int c = 0; c <= rdl; c++) begin
                chk({nm, "/wait"}, stall, 1);
                chk({nm, "/noreq"}, dreq, 0);
                chk({nm, "/early"}, vout, 0);
                rvalid = (c == rdl);
                rdata = (c == rdl) ? rdat : $urandom;
                tick();
            end
            rvalid = 1'b0;
            chk({nm, "/valid"}, vout, 1);
            chk({nm, "/value"}, rdval, eval);
            chk({nm, "/rd"}, rdo, rdi);
            chk({nm, "/rdw"}, rdwo, rwi);
        end
        tick();
        chk({nm, "/pulse"}, vout, 0);
    endtask

    typedef struct {
        string       nm;
        logic [6:0]  op;
        logic [2:0]  f;
        logic [31:0] r;
        logic [31:0] d2;
        logic [4:0]  rdi;
        int          gd;
        logic [31:0] rdat;
        logic [3:0]  be;
        logic [31:0] wd;
        logic [31:0] val;
        logic        mis;
    } vec_t;

    vec_t tbl[$];

    initial begin
        tbl.push_back('{"addi",  OP_ALU, 3'b000, 32'h5,   32'h0,        5'd3, 0, 32'h0,        4'h0, 32'h0,        32'h5,        1'b0});
        tbl.push_back('{"sw",    OP_ST,  3'b010, 32'h100, 32'hDEADBEEF, 5'd0, 3, 32'h0,        4'hF, 32'hDEADBEEF, 32'h0,        1'b0});
        tbl.push_back('{"lb",    OP_LD,  3'b000, 32'h103, 32'h0,        5'd7, 1, 32'h80FF0000, 4'hF, 32'h0,        32'hFFFFFF80, 1'b0});
        tbl.push_back('{"lbu",   OP_LD,  3'b100, 32'h103, 32'h0,        5'd8, 0, 32'h80FF0000, 4'hF, 32'h0,        32'h00000080, 1'b0});
        tbl.push_back('{"lh_mis",OP_LD,  3'b001, 32'h101, 32'h0,        5'd9, 0, 32'h0,        4'h0, 32'h0,        32'h0,        1'b1});
        tbl.push_back('{"lh",    OP_LD,  3'b001, 32'h102, 32'h0,        5'd4, 2, 32'h80FF0000, 4'hF, 32'h0,        32'hFFFF80FF, 1'b0});
        tbl.push_back('{"lhu",   OP_LD,  3'b101, 32'h102, 32'h0,        5'd5, 0, 32'h80FF0000, 4'hF, 32'h0,        32'h000080FF, 1'b0});
        tbl.push_back('{"lw",    OP_LD,  3'b010, 32'h204, 32'h0,        5'd6, 1, 32'h12345678, 4'hF, 32'h0,        32'h12345678, 1'b0});
        tbl.push_back('{"sb",    OP_ST,  3'b000, 32'h201, 32'h123456AB, 5'd0, 0, 32'h0,        4'b0010, 32'hABABABAB, 32'h0,     1'b0});
        tbl.push_back('{"sw_mis",OP_ST,  3'b010, 32'h102, 32'h1,        5'd0, 0, 32'h0,        4'h0, 32'h0,        32'h0,        1'b1});
        tbl.push_back('{"f3_011",OP_LD,  3'b011, 32'h100, 32'h0,        5'd2, 0, 32'h0,        4'h0, 32'h0,        32'h0,        1'b1});
        tbl.push_back('{"f3_110",OP_ST,  3'b110, 32'h100, 32'h0,        5'd0, 0, 32'h0,        4'h0, 32'h0,        32'h0,        1'b1});

        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        chk("rst/stall", stall, 0);
        chk("rst/req", dreq, 0);
        chk("rst/valid", vout, 0);
        chk("rst/mis", mis, 0);
        chk("rst/addr", daddr, 0);
        chk("rst/be", dbe, 0);
        chk("rst/value", rdval, 0);

        foreach (tbl[i])
            run(tbl[i].nm, tbl[i].op, tbl[i].f, tbl[i].r, tbl[i].d2,
                tbl[i].rdi, 1'b1, tbl[i].gd, 1, tbl[i].rdat, tbl[i].be,
                tbl[i].wd, tbl[i].val, tbl[i].mis);

        // Back-to-back ADD then SH; valid_in held high while stalled.
        valid_in = 1'b1; opc = 7'b0110011; f3 = 3'b000;
        res = 32'h77; rd = 5'd10; rdw = 1'b1;
        tick();
        chk("b2b/add_valid", vout, 1);
        chk("b2b/add_value", rdval, 32'h77);
        opc = OP_ST; f3 = 3'b001; res = 32'h202; rs2 = 32'h00001234;
        tick();
        opc = 7'b0110011; res = 32'h99;
        chk("b2b/sh_req", dreq, 1);
        chk("b2b/sh_be", dbe, 4'b1100);
        chk("b2b/sh_wdata", dwdata, 32'h12341234);
        chk("b2b/stalled_valid", vout, 0);
        tick();
        chk("b2b/ignored", vout, 0);
        valid_in = 1'b0;
        gnt = 1'b1;
        tick();
        gnt = 1'b0;
        chk("b2b/sh_valid", vout, 1);
        chk("b2b/sh_rdw", rdwo, 0);
        tick();

        // Reset in WAIT_RVALID aborts the load; late rvalid ignored.
        valid_in = 1'b1; opc = OP_LD; f3 = 3'b010; res = 32'h40; rd = 5'd1;
        tick();
        valid_in = 1'b0; gnt = 1'b1;
        tick();
        gnt = 1'b0;
        chk("abort/in_rvalid", stall, 1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("abort/stall", stall, 0);
        chk("abort/req", dreq, 0);
        chk("abort/valid", vout, 0);
        chk("abort/addr", daddr, 0);
        chk("abort/be", dbe, 0);
        chk("abort/rd", rdo, 0);
        rvalid = 1'b1; rdata = 32'hCAFEF00D;
        tick();
        rvalid = 1'b0;
        chk("abort/late_rvalid", vout, 0);
        chk("abort/late_value", rdval, 0);

        // Reset while waiting for grant drops the request next cycle.
        valid_in = 1'b1; opc = OP_ST; f3 = 3'b010; res = 32'h80;
        tick();
        valid_in = 1'b0;
        chk("abort_gnt/req", dreq, 1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("abort_gnt/req_drop", dreq, 0);
        gnt = 1'b1;
        tick();
        gnt = 1'b0;
        chk("abort_gnt/no_valid", vout, 0);

        for (int n = 0; n < 150; n++) begin
            int k = $urandom_range(0, 2);
            logic [6:0] op;
            logic [2:0] f;
            logic [31:0] r = $urandom;
            logic [31:0] d2 = $urandom;
            logic [31:0] rd_d = $urandom;
            logic e_mis;
            logic [31:0] e_val;
            logic [2:0] st_f3 [6] = '{3'd0, 3'd1, 3'd2, 3'd3, 3'd6, 3'd7};
            op = (k == 0) ? OP_ALU : (k == 1) ? OP_LD : OP_ST;
            f = (k == 2) ? st_f3[$urandom_range(0, 5)] : 3'($urandom);
            e_mis = (k != 0) && m_mis(f, r);
            e_val = (k == 0) ? r : (k == 1 && !e_mis) ? m_ld(f, r, rd_d) : 32'h0;
            run("rand", op, f, r, d2, 5'($urandom), 1'($urandom),
                $urandom_range(0, 3), $urandom_range(0, 3), rd_d,
                e_mis ? 4'h0 : m_be(k == 2, f, r),
                (k == 2 && !e_mis) ? m_wd(f, d2) : 32'h0, e_val, e_mis);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/mem_access.md
MEM_ACCESS -- requirements
Module: mem_access

Interface
REQ-001 req  in  1  stage clock (driven by ctrl); all state changes on rising edge.
REQ-002 reset  in  1  synchronous, active-high reset, sampled on rising req.
REQ-003 valid_in  in  1  execute result valid this cycle.
REQ-004 alu_opcode_in  in  7  RV32I opcode of the instruction in flight.
REQ-005 funct3_in  in  3  access size/sign for load/store.
REQ-006 result_in  in  32  ALU result; effective address for load/store.
REQ-007 rs2_value_in  in  32  store data.
REQ-008 rd_in / rd_write_in  in  5 / 1  destination register and write enable.
REQ-009 stall_out  out  1  stage busy; upstream holds its inputs.
REQ-010 data_req_out / data_gnt_in  out / in  1 / 1  data bus request/grant.
REQ-011 data_addr_out  out  32  word-aligned address ({addr[31:2],2'b00}).
REQ-012 data_we_out / data_be_out  out / out  1 / 4  write enable, byte enables.
REQ-013 data_wdata_out  out  32  lane-shifted store data.
REQ-014 data_rvalid_in / data_rdata_in  in / in  1 / 32  read response.
REQ-015 valid_out / rd_out / rd_write_out / rd_value_out  out  1/5/1/32  writeback result.
REQ-016 misaligned_out  out  1  one-cycle pulse with a faulting valid_out.

Function
REQ-017 The FSM SHALL have states IDLE, WAIT_GNT and WAIT_RVALID; stall_out SHALL equal (state != IDLE).
REQ-018 In IDLE with valid_in=1 and a non-memory opcode, the block SHALL register rd_in, rd_write_in and result_in to the outputs and assert valid_out one cycle later.
REQ-019 In IDLE with valid_in=1 and opcode LOAD (0000011) or STORE (0100011), aligned, the block SHALL capture the operation and enter WAIT_GNT.
REQ-020 In WAIT_GNT, data_req_out SHALL be 1 and addr/we/be/wdata SHALL stay stable until the cycle data_gnt_in=1.
REQ-021 A store granted in WAIT_GNT SHALL return to IDLE and pulse valid_out with rd_write_out=0 in the next cycle.
REQ-022 A load granted in WAIT_GNT SHALL enter WAIT_RVALID; data_rvalid_in outside WAIT_RVALID SHALL be ignored.
REQ-023 In WAIT_RVALID, on data_rvalid_in=1 the block SHALL extract the lane by addr[1:0], sign-extend (LB 000, LH 001) or zero-extend (LBU 100, LHU 101), pass LW 010 unchanged, drive rd_value_out with valid_out the next cycle, and return to IDLE.
REQ-024 Byte enables SHALL be: SB 0001<<addr[1:0]; SH 0011<<addr[1:0]; SW 1111; loads 1111 with we=0.
REQ-025 Store data SHALL be replicated per lane: SB {4{b}}, SH {2{h}}, SW unchanged.
REQ-026 Halfword access with addr[0]=1, or word access with addr[1:0]!=0, SHALL issue no bus request and SHALL pulse valid_out and misaligned_out one cycle later with rd_write_out=0.
REQ-027 valid_out SHALL be a single-cycle pulse per accepted instruction; valid_in SHALL be ignored while stall_out=1.
REQ-028 Unsupported funct3 values (011, 110, 111) on load/store SHALL be treated as misaligned.

Reset
REQ-029 On reset the FSM SHALL enter IDLE, and all outputs SHALL be 0, including stall_out, data_req_out, valid_out and misaligned_out.
REQ-030 Reset asserted mid-transaction SHALL abort it: data_req_out drops in the next cycle and no valid_out is produced for the aborted access.

Structure
REQ-031 Opcode constants (OPC_LOAD, OPC_STORE), funct3 size codes and the FSM state enum SHALL live in the shared package core_pkg.
REQ-032 Lane extraction and sign extension SHALL be a combinational sub-module named load_align.

Verification
REQ-033 ADDI result 0x00000005, rd=3 -> the next cycle gives valid_out=1, rd_out=3, rd_value_out=0x5, and no data_req_out.
REQ-034 SW 0xDEADBEEF to 0x100, gnt delayed 3 cycles -> data_req_out is held 4 cycles with addr 0x100, be 1111, and stable wdata; valid_out pulses with rd_write_out=0.
REQ-035 LB from 0x103 with rdata 0x80FF0000 -> be=1111, rd_value_out=0xFFFFFF80; LBU from the same address -> 0x00000080.
REQ-036 LH from 0x101 -> no data_req_out; valid_out=1 and misaligned_out=1 one cycle later.
REQ-037 LW with gnt, then reset asserted in WAIT_RVALID before rvalid -> the FSM is in IDLE, all outputs are 0, and a later rvalid is ignored.
REQ-038 Back-to-back ADD then SH to 0x202 with data 0x1234 -> the ADD result is presented first, then be=1100 and wdata=0x12341234.
